// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC core front end.
package npc_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_t;

endpackage

// File: rtl/ifu_pc_reg.sv
// Fetch PC register: a redirect wins over the sequential +4 step.
// Addition wraps modulo 2^XLEN.
module ifu_pc_reg
  import npc_pkg::*;
#(
  parameter int              W     = 32,
  parameter logic [W-1:0]    RST_PC = 32'h8000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redirect_valid,
  input  logic [W-1:0] redirect_pc,
  input  logic         inc,
  output logic [W-1:0] pc
);

  // Redirect target is word-aligned; low two bits are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 pc <= RST_PC;
    else if (redirect_valid) pc <= {redirect_pc[W-1:2], 2'b00};
    else if (inc)            pc <= pc + W'(4);
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding imem request, single-entry
// instruction buffer towards decode, redirect handling with stale-response
// discard.
// Optional feature: define IFU_RSP_BYPASS_EN to forward the memory response
// combinationally to decode in the response cycle.
module ifu_fetch
  import npc_pkg::*;
#(
  parameter int                 XLEN     = 32,
  parameter logic [XLEN-1:0]    RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc
);

  ifu_state_t      state;
  logic            discard_q;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] pc;
  logic            req_fire;
  logic            bypass;
  logic            inc;

  assign req_fire = imem_req_valid & imem_req_ready;

`ifdef IFU_RSP_BYPASS_EN
  // Live response goes straight to decode unless it is stale or being killed.
  assign bypass = (state == S_WAIT) & imem_rsp_valid & ~discard_q & ~redirect_valid;
  assign inst   = bypass ? imem_rsp_data : inst_q;
`else
  assign bypass = 1'b0;
  assign inst   = inst_q;
`endif

  // A redirect in S_HOLD suppresses the transfer so the wrong-path word dies.
  assign inst_valid     = ((state == S_HOLD) & ~redirect_valid) | bypass;
  assign inc            = inst_valid & inst_ready;
  assign imem_req_valid = (state == S_REQ) & ~rst;
  assign imem_req_addr  = pc;
  assign inst_pc        = pc;

  ifu_pc_reg #(.W(XLEN), .RST_PC(RESET_PC)) u_pc (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inc            (inc),
    .pc             (pc)
  );

  // Fetch sequencing, stale-response tracking and instruction capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_REQ;
      discard_q <= 1'b0;
      inst_q    <= NOP_INST;
    end else begin
      case (state)
        S_REQ: begin
          if (req_fire) begin
            state <= S_WAIT;
            // Request left with the old PC; its response must be dropped.
            if (redirect_valid) discard_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            // The single outstanding response has drained either way.
            discard_q <= 1'b0;
            if (redirect_valid || discard_q) begin
              state <= S_REQ;
            end else if (inc) begin
              state <= S_REQ;
            end else begin
              inst_q <= imem_rsp_data;
              state  <= S_HOLD;
            end
          end else if (redirect_valid) begin
            discard_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid || inc) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus a randomized run
// checked by an architectural model (expected PC stream and memory contents).
module tb_ifu_fetch;
  import npc_pkg::*;

`ifdef IFU_RSP_BYPASS_EN
  localparam int INST_PERIOD = 2;
`else
  localparam int INST_PERIOD = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int delivered = 0;

  bit mem_auto = 0;
  bit rand_drive = 0;
  int max_delay = 0;

  bit          hs_seen, rsp_seen;
  logic [31:0] hs_addr;
  bit          pend;
  logic [31:0] paddr;
  int          cnt;

  logic [31:0] exp_pc = 32'h8000_0000;
  bit          stall_prev = 0;
  logic [31:0] stall_addr;

  // Memory image: odd multiplier makes every aligned address map to a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // Monitor at negedge: architectural model of the fetch stream.
  task sample();
    hs_seen  = imem_req_valid && imem_req_ready;
    hs_addr  = imem_req_addr;
    rsp_seen = imem_rsp_valid;
    if (rst) begin
      exp_pc     = 32'h8000_0000;
      stall_prev = 0;
      return;
    end
    if (hs_seen) begin
      checks++;
      if (hs_addr !== exp_pc) begin
        errors++;
        $display("FAIL sb_req_addr: got %h expected %h", hs_addr, exp_pc);
      end
    end
    if (stall_prev) begin
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== stall_addr) begin
        errors++;
        $display("FAIL sb_req_stable: got valid=%b addr=%h expected valid=1 addr=%h",
                 imem_req_valid, imem_req_addr, stall_addr);
      end
    end
    if (redirect_valid) begin
      checks++;
      if (inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL sb_redirect_kill: got inst_valid=%b expected 0", inst_valid);
      end
    end
    if (inst_valid === 1'b1) begin
      checks++;
      if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
        errors++;
        $display("FAIL sb_inst: got pc=%h inst=%h expected pc=%h inst=%h",
                 inst_pc, inst, exp_pc, mem_word(exp_pc));
      end
    end
    stall_prev = imem_req_valid && !imem_req_ready && !redirect_valid;
    stall_addr = imem_req_addr;
    if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    else if (inst_valid && inst_ready) begin
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
  endtask

  // Memory responder: one response per accepted request after 0..max_delay cycles.
  task mem_step();
    if (rsp_seen) imem_rsp_valid = 1'b0;
    if (hs_seen) begin
      pend  = 1;
      paddr = hs_addr;
      cnt   = $urandom_range(max_delay, 0);
    end
    if (pend) begin
      if (cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(paddr);
        pend           = 0;
      end else cnt--;
    end
    imem_req_ready = rand_drive ? ($urandom_range(1, 0) == 1) : 1'b1;
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
    if (mem_auto) mem_step();
    if (rand_drive) begin
      inst_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(15, 0) == 0) begin
        redirect_valid = 1'b1;
        case ($urandom_range(2, 0))
          0:       redirect_pc = 32'h8000_0000 + $urandom_range(255, 0);
          1:       redirect_pc = 32'hFFFF_FFF0 + $urandom_range(15, 0);
          default: redirect_pc = $urandom;
        endcase
      end else redirect_valid = 1'b0;
    end
  endtask

  task do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    inst_ready     = 1'b0;
    pend           = 0;
    mem_auto       = 0;
    rand_drive     = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got req_valid=%b inst_valid=%b expected 0 0", imem_req_valid, inst_valid);
    end
    do_reset();
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000 || inst_valid !== 1'b0 || inst !== 32'h0000_0013) begin
      errors++;
      $display("FAIL reset_release: got valid=%b addr=%h ivalid=%b inst=%h expected 1 80000000 0 00000013",
               imem_req_valid, imem_req_addr, inst_valid, inst);
    end
    // Reset asserted while waiting on memory.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait: got req_valid=%b inst_valid=%b expected 0 0", imem_req_valid, inst_valid);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
      errors++;
      $display("FAIL reset_mid_wait_release: got valid=%b addr=%h expected 1 80000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task test_stream();
    int          c0, n;
    int          cy[3];
    logic [31:0] pcs[3];
    logic [31:0] ws[3];
    do_reset();
    mem_auto = 1; max_delay = 0; imem_req_ready = 1'b1; inst_ready = 1'b1;
    c0 = cyc; n = 0;
    for (int i = 0; i < 30 && n < 3; i++) begin
      tick();
      #1;
      if (inst_valid === 1'b1) begin
        cy[n] = cyc; pcs[n] = inst_pc; ws[n] = inst; n++;
      end
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL stream_count: got %0d insts expected 3", n);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (pcs[i] !== 32'h8000_0000 + 32'(4 * i) || ws[i] !== mem_word(32'h8000_0000 + 32'(4 * i))) begin
          errors++;
          $display("FAIL stream_word%0d: got pc=%h inst=%h expected pc=%h", i, pcs[i], ws[i], 32'h8000_0000 + 32'(4 * i));
        end
      end
      checks++;
      if (cy[0] - c0 != INST_PERIOD - 1 || cy[1] - cy[0] != INST_PERIOD || cy[2] - cy[1] != INST_PERIOD) begin
        errors++;
        $display("FAIL stream_timing: got first=%0d gaps=%0d,%0d expected %0d,%0d,%0d",
                 cy[0] - c0, cy[1] - cy[0], cy[2] - cy[1], INST_PERIOD - 1, INST_PERIOD, INST_PERIOD);
      end
    end
  endtask

  task test_backpressure();
    bit          got;
    logic [31:0] w, p;
    do_reset();
    mem_auto = 1; max_delay = 0; imem_req_ready = 1'b1; inst_ready = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      #1;
      got = (inst_valid === 1'b1);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL bp_timeout: got no inst_valid expected one within 20 cycles");
    end
    w = inst; p = inst_pc;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      checks++;
      if (inst_valid !== 1'b1 || inst !== w || inst_pc !== p || imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_stable%0d: got iv=%b inst=%h pc=%h rv=%b expected 1 %h %h 0",
                 i, inst_valid, inst, inst_pc, imem_req_valid, w, p);
      end
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== p + 32'd4) begin
      errors++;
      $display("FAIL bp_release: got iv=%b rv=%b addr=%h expected 0 1 %h", inst_valid, imem_req_valid, imem_req_addr, p + 32'd4);
    end
  endtask

  task test_redirect_wait();
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'h8000_0000); inst_ready = 1'b1;
    #1;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rw_stale_rsp: got inst_valid=%b expected 0", inst_valid);
    end
    tick();
    imem_rsp_valid = 1'b0; inst_ready = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
      errors++;
      $display("FAIL rw_next_req: got iv=%b rv=%b addr=%h expected 0 1 80000100", inst_valid, imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'h8000_0100);
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0100 || inst !== mem_word(32'h8000_0100)) begin
      errors++;
      $display("FAIL rw_target_inst: got iv=%b pc=%h inst=%h expected 1 80000100 %h",
               inst_valid, inst_pc, inst, mem_word(32'h8000_0100));
    end
  endtask

  task test_redirect_hold();
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'h8000_0000);
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL rh_hold: got inst_valid=%b expected 1", inst_valid);
    end
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    #1;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rh_kill: got inst_valid=%b expected 0", inst_valid);
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
      errors++;
      $display("FAIL rh_next_req: got iv=%b rv=%b addr=%h expected 0 1 80000100", inst_valid, imem_req_valid, imem_req_addr);
    end
    inst_ready = 1'b0;
  endtask

  task test_wrap();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_top: got rv=%b addr=%h expected 1 fffffffc", imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'hFFFF_FFFC); inst_ready = 1'b1;
    tick();
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (imem_req_valid === 1'b1) break;
      tick();
    end
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_zero: got rv=%b addr=%h expected 1 00000000", imem_req_valid, imem_req_addr);
    end
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000) begin
        errors++;
        $display("FAIL wrap_stall%0d: got rv=%b addr=%h expected 1 00000000", i, imem_req_valid, imem_req_addr);
      end
    end
  endtask

  task test_random();
    do_reset();
    mem_auto = 1; rand_drive = 1; max_delay = 3; delivered = 0;
    repeat (3000) tick();
    rand_drive = 0; redirect_valid = 1'b0;
    tick();
    checks++;
    if (delivered < 50) begin
      errors++;
      $display("FAIL random_progress: got %0d delivered expected at least 50", delivered);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
